mtm_row_collector: RTL and testbench

MTM_ROW_COLLECTOR -- requirements
Module: mtm_row_collector

---
 rtl/mtm_row_collector.sv | 154 +++++++++++++++
 tb/tb_mtm_row_collector.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/mtm_row_collector.sv
// -----------------------------------------------------------------------------
// mtm_row_collector
//
// Collects transposed rows produced by an upstream matrix-transpose unit into
// two ping-pong banks of NUM_PE rows each and replays complete matrices to a
// downstream consumer over a valid/ready handshake. There is no upstream
// backpressure: a row arriving while the bank being written is still full is
// dropped.
//
// Optional feature: define MTM_COLLECT_OVF_EN to add the sticky `ovf` output.
// It goes high on the first dropped row and stays high until reset.
//
// Parameters
//   DATA_WIDTH : bit width of one matrix element
//   NUM_PE     : elements per row and rows per matrix
//
// Ports
//   clk      in   single clock; all state changes on its rising edge
//   rst      in   synchronous, active-low reset
//   in_val   in   in_row is valid this cycle
//   in_row   in   one row, element 0 in the most significant slot
//   out_val  out  out_row holds a valid stored row
//   out_rdy  in   downstream accepts out_row
//   out_row  out  row being presented
//   out_last out  out_row is the final row of its matrix
//   full     out  both banks hold complete, undrained matrices
//   ovf      out  sticky overflow flag (only with MTM_COLLECT_OVF_EN)
// -----------------------------------------------------------------------------
module mtm_row_collector #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_PE     = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_val,
  input  logic [0:NUM_PE-1][DATA_WIDTH-1:0]    in_row,
  output logic                                 out_val,
  input  logic                                 out_rdy,
  output logic [0:NUM_PE-1][DATA_WIDTH-1:0]    out_row,
  output logic                                 out_last,
  output logic                                 full
`ifdef MTM_COLLECT_OVF_EN
  ,
  output logic                                 ovf
`endif
);

  localparam int CNT_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(NUM_PE - 1);

  typedef logic [0:NUM_PE-1][DATA_WIDTH-1:0] row_t;

  // Row storage: bank-major, then row index. No reset is needed on the data;
  // validity is carried entirely by the per-bank full flags.
  row_t mem_q [0:1][0:NUM_PE-1];

  logic [1:0]       bank_full_q, bank_full_d;
  logic             wr_bank_q,   wr_bank_d;
  logic [CNT_W-1:0] wr_cnt_q,    wr_cnt_d;
  logic             rd_bank_q,   rd_bank_d;
  logic [CNT_W-1:0] rd_cnt_q,    rd_cnt_d;

  logic wr_en;
  logic wr_done;
  logic xfer;
  logic rd_done;

  // The write gate uses the full flag as registered at cycle start, so a bank
  // released by a read in this same cycle still refuses this cycle's row.
  assign wr_en   = in_val && !bank_full_q[wr_bank_q];
  assign wr_done = wr_en && (wr_cnt_q == LAST_ROW);

  assign out_val  = bank_full_q[rd_bank_q];
  assign out_row  = mem_q[rd_bank_q][rd_cnt_q];
  assign out_last = out_val && (rd_cnt_q == LAST_ROW);
  assign full     = &bank_full_q;

  assign xfer    = out_val && out_rdy;
  assign rd_done = xfer && (rd_cnt_q == LAST_ROW);

  always_comb begin
    bank_full_d = bank_full_q;
    wr_bank_d   = wr_bank_q;
    wr_cnt_d    = wr_cnt_q;
    rd_bank_d   = rd_bank_q;
    rd_cnt_d    = rd_cnt_q;

    if (wr_en) begin
      if (wr_done) begin
        wr_cnt_d  = '0;
        wr_bank_d = ~wr_bank_q;
      end else begin
        wr_cnt_d = wr_cnt_q + 1'b1;
      end
    end

    if (xfer) begin
      if (rd_done) begin
        rd_cnt_d  = '0;
        rd_bank_d = ~rd_bank_q;
      end else begin
        rd_cnt_d = rd_cnt_q + 1'b1;
      end
    end

    // Completing a write needs an empty bank and releasing needs a full one,
    // so when both fire in one cycle they always touch different banks.
    if (wr_done) bank_full_d[wr_bank_q] = 1'b1;
    if (rd_done) bank_full_d[rd_bank_q] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bank_full_q <= '0;
      wr_bank_q   <= 1'b0;
      wr_cnt_q    <= '0;
      rd_bank_q   <= 1'b0;
      rd_cnt_q    <= '0;
    end else begin
      bank_full_q <= bank_full_d;
      wr_bank_q   <= wr_bank_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_bank_q   <= rd_bank_d;
      rd_cnt_q    <= rd_cnt_d;
    end
  end

  // Rows presented during reset must not land in storage.
  always_ff @(posedge clk) begin
    if (rst && wr_en) begin
      mem_q[wr_bank_q][wr_cnt_q] <= in_row;
    end
  end

`ifdef MTM_COLLECT_OVF_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (in_val && bank_full_q[wr_bank_q]) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_mtm_row_collector.sv
// -----------------------------------------------------------------------------
// Testbench for mtm_row_collector (DATA_WIDTH=8, NUM_PE=4).
// A queue-based reference tracks complete matrices awaiting output, the rows
// of the matrix currently being assembled, and the number of undrained
// matrices; expected outputs are derived from that every cycle.
// -----------------------------------------------------------------------------
module tb_mtm_row_collector;

  localparam int DW = 8;
  localparam int NP = 4;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       in_val;
  logic [0:NP-1][DW-1:0]      in_row;
  logic                       out_val;
  logic                       out_rdy;
  logic [0:NP-1][DW-1:0]      out_row;
  logic                       out_last;
  logic                       full;
`ifdef MTM_COLLECT_OVF_EN
  logic                       ovf;
`endif

  mtm_row_collector #(.DATA_WIDTH(DW), .NUM_PE(NP)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_val   (in_val),
    .in_row   (in_row),
    .out_val  (out_val),
    .out_rdy  (out_rdy),
    .out_row  (out_row),
    .out_last (out_last),
    .full     (full)
`ifdef MTM_COLLECT_OVF_EN
    ,
    .ovf      (ovf)
`endif
  );

  always #5 clk = ~clk;

  // Reference state
  logic [31:0] outq [$];   // rows of complete matrices, oldest first
  logic [31:0] part [$];   // rows of the matrix being assembled
  int          mats;       // complete matrices not yet fully drained
  int          sent;       // rows already sent from the oldest matrix
  logic        ovf_m;

  int n_checks = 0;
  int n_fail   = 0;
  int n_out    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mkrow(input logic [7:0] b);
    logic [7:0] b1, b2, b3;
    b1 = b + 8'd1;
    b2 = b + 8'd2;
    b3 = b + 8'd3;
    return {b, b1, b2, b3};
  endfunction

  // Row r of the verification pattern: {10r+0A, 10r+0B, 10r+0C, 10r+0D}
  function automatic logic [31:0] prow(input int r);
    logic [7:0] b;
    b = 8'(r * 16 + 10);
    return mkrow(b);
  endfunction

  task automatic model_reset();
    outq.delete();
    part.delete();
    mats  = 0;
    sent  = 0;
    ovf_m = 1'b0;
  endtask

  // One clock cycle: apply inputs, check outputs against the reference
  // (outputs depend only on registered state), then advance the reference.
  task automatic step(input logic v, input logic [31:0] row, input logic rdy, input logic rstn);
    int m0;
    @(negedge clk);
    in_val  = v;
    in_row  = row;
    out_rdy = rdy;
    rst     = rstn;
    #1;
    chk("out_val", 32'(out_val), 32'(mats > 0));
    chk("full", 32'(full), 32'(mats == 2));
    if (mats > 0) begin
      chk("out_row", out_row, outq[0]);
      chk("out_last", 32'(out_last), 32'(sent == NP - 1));
    end else begin
      chk("out_last_idle", 32'(out_last), 32'd0);
    end
`ifdef MTM_COLLECT_OVF_EN
    chk("ovf", 32'(ovf), 32'(ovf_m));
`endif
    if (!rstn) begin
      model_reset();
    end else begin
      m0 = mats;
      if (m0 > 0 && rdy) begin
        $display("out row %h last=%0d", outq[0], (sent == NP - 1));
        n_out++;
        void'(outq.pop_front());
        sent++;
        if (sent == NP) begin
          sent = 0;
          mats--;
        end
      end
      if (v) begin
        if (m0 < 2) begin
          part.push_back(row);
          if (part.size() == NP) begin
            foreach (part[i]) outq.push_back(part[i]);
            part.delete();
            mats++;
          end
        end else begin
          ovf_m = 1'b1;
        end
      end
    end
  endtask

  initial begin
    int out_before;
    rst = 1'b0; in_val = 1'b0; in_row = '0; out_rdy = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();

    // Reset state, with in_val asserted during reset (must be ignored)
    step(1'b1, prow(9), 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1);

    // Single matrix, consumer always ready
    for (int r = 0; r < 4; r++) step(1'b1, prow(r), 1'b1, 1'b1);
    for (int k = 0; k < 6; k++) step(1'b0, '0, 1'b1, 1'b1);

    // Two matrices stored, ninth row dropped, then full drain
    for (int r = 0; r < 9; r++) step(1'b1, prow(r), 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    out_before = n_out;
    for (int k = 0; k < 10; k++) step(1'b0, '0, 1'b1, 1'b1);
    chk("drain_count", 32'(n_out - out_before), 32'd8);

    // Stalled drain with out_rdy toggling
    for (int r = 0; r < 4; r++) step(1'b1, prow(r + 4), 1'b0, 1'b1);
    for (int k = 0; k < 10; k++) step(1'b0, '0, 1'(k % 2 == 0), 1'b1);

    // Reset mid-matrix, then a fresh matrix
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, prow(0), 1'b1, 1'b1);
    step(1'b1, prow(1), 1'b1, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0);
    for (int r = 0; r < 4; r++) step(1'b1, mkrow(8'(8'h20 + 8'(r * 16))), 1'b1, 1'b1);
    for (int k = 0; k < 6; k++) step(1'b0, '0, 1'b1, 1'b1);

    // Three back-to-back matrices, consumer ready
    out_before = n_out;
    for (int r = 0; r < 12; r++) step(1'b1, prow(r), 1'b1, 1'b1);
    for (int k = 0; k < 6; k++) step(1'b0, '0, 1'b1, 1'b1);
    chk("b2b_count", 32'(n_out - out_before), 32'd12);

    // Randomised traffic, including overflow, handshake stalls and resets
    for (int k = 0; k < 600; k++) begin
      step(1'($urandom_range(0, 99) < 65), $urandom, 1'($urandom_range(0, 99) < 45),
           1'($urandom_range(0, 99) != 0));
    end
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
